// File: rtl/wb_mem_stage.sv
// Writeback/memory stage: issues data-memory loads/stores over a req/gnt/rvalid bus,
// formats load/store data and drives the register-file write port.
module wb_mem_stage #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  A3_W,
    input  logic [31:0] RD2_W,
    input  logic [31:0] ALUResultW,
    input  logic [31:0] PCNextW,
    input  logic        RegWriteW,
    input  logic        MemReadW,
    input  logic        MemWriteW,
    input  logic [1:0]  ResultSrcW,
    input  logic [2:0]  Funct3W,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [3:0]  dmem_be,
    output logic [31:0] dmem_wdata,
    input  logic        dmem_gnt,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata,
    output logic        rf_we,
    output logic [4:0]  rf_a3,
    output logic [31:0] rf_wd,
    output logic        StallW,
    output logic        misalign_exc,
    output logic        bus_err
);

    localparam logic [15:0] TMO = 16'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        DATA
    } state_t;

    state_t      state;
    logic [15:0] tmo_cnt;

    logic        is_mem;
    logic        misaligned;
    logic        start;
    logic        timeout;
    logic        a3_nz;
    logic [1:0]  lane;
    logic [1:0]  size;
    logic [31:0] shifted;
    logic [31:0] load_ext;
    logic [31:0] wb_data;

    assign is_mem  = MemReadW | MemWriteW;
    assign lane    = ALUResultW[1:0];
    assign size    = Funct3W[1:0];
    assign a3_nz   = (A3_W != 5'd0);
    assign rf_a3   = A3_W;
    assign timeout = (state != IDLE) && (tmo_cnt == TMO);

    // Half needs even address, word (and reserved size 11) needs word alignment.
    assign misaligned = is_mem &
                        (((size == 2'b01) & lane[0]) | (size[1] & (lane != 2'b00)));
    assign start      = is_mem & ~misaligned;

    assign dmem_we   = MemWriteW;
    assign dmem_addr = {ALUResultW[31:2], 2'b00};

    always_comb begin
        dmem_be    = 4'b1111;
        dmem_wdata = RD2_W;
        case (size)
            2'b00: begin
                dmem_be    = 4'b0001 << lane;
                dmem_wdata = {4{RD2_W[7:0]}};
            end
            2'b01: begin
                dmem_be    = lane[1] ? 4'b1100 : 4'b0011;
                dmem_wdata = {2{RD2_W[15:0]}};
            end
            default: begin
                dmem_be    = 4'b1111;
                dmem_wdata = RD2_W;
            end
        endcase
    end

    assign shifted = dmem_rdata >> {lane, 3'b000};

    always_comb begin
        load_ext = dmem_rdata;
        case (Funct3W)
            3'b000:  load_ext = {{24{shifted[7]}}, shifted[7:0]};
            3'b001:  load_ext = {{16{shifted[15]}}, shifted[15:0]};
            3'b100:  load_ext = {24'd0, shifted[7:0]};
            3'b101:  load_ext = {16'd0, shifted[15:0]};
            default: load_ext = dmem_rdata;
        endcase
    end

    always_comb begin
        wb_data = '0;
        case (ResultSrcW)
            2'b00:   wb_data = ALUResultW;
            2'b01:   wb_data = load_ext;
            2'b10:   wb_data = PCNextW;
            default: wb_data = '0;
        endcase
    end

    // Outputs decode state and live W-stage inputs so a non-memory write and the
    // first stall cycle land in the same cycle the instruction arrives.
    always_comb begin
        dmem_req     = 1'b0;
        rf_we        = 1'b0;
        rf_wd        = wb_data;
        StallW       = 1'b0;
        misalign_exc = 1'b0;
        bus_err      = 1'b0;
        if (reset) begin
            case (state)
                IDLE: begin
                    if (!is_mem) begin
                        rf_we = RegWriteW & a3_nz & (ResultSrcW != 2'b11);
                    end else if (misaligned) begin
                        misalign_exc = 1'b1;
                    end else begin
                        StallW = 1'b1;
                    end
                end
                ADDR: begin
                    if (timeout) begin
                        bus_err = 1'b1;
                    end else begin
                        dmem_req = 1'b1;
                        StallW   = ~(MemWriteW & dmem_gnt);
                    end
                end
                DATA: begin
                    if (timeout) begin
                        bus_err = 1'b1;
                    end else if (dmem_rvalid) begin
                        rf_we = RegWriteW & a3_nz;
                        rf_wd = load_ext;
                    end else begin
                        StallW = 1'b1;
                    end
                end
                default: begin
                    StallW = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state   <= IDLE;
            tmo_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        state   <= ADDR;
                        tmo_cnt <= '0;
                    end
                end
                ADDR: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (dmem_gnt) begin
                            state <= MemWriteW ? IDLE : DATA;
                        end
                    end
                end
                DATA: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else begin
                        tmo_cnt <= tmo_cnt + 16'd1;
                        if (dmem_rvalid) begin
                            state <= IDLE;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule
